fetch_controller: RTL

Sequences the synchronous-read instruction memory for the fetch stage of the pipelined RV32 core. It owns the PC, issues one word read per cycle, buffers returning words in a 2-entry fetch buffer, and drives the registered IF/ID outputs. It honours hazard-unit stalls without dropping or duplicating instructions, and applies branch/jump redirects from EX by squashing wrong-path fetches.

---
 rtl/fetch_controller_if.sv | 39 +++
 rtl/fetch_controller.sv | 120 ++++++++++++
 2 files changed

// File: rtl/fetch_controller_if.sv
// Fetch-stage bus: hazard/redirect inputs, instruction memory port and
// the registered IF/ID outputs, bundled for the fetch controller.
interface fetch_controller_if;
    logic        stall_in;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_read_address;
    logic [31:0] imem_instruction;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instruction;
    logic        misaligned_error;

    // Fetch controller side
    modport master (
        input  stall_in,
        input  redirect_valid,
        input  redirect_pc,
        input  imem_instruction,
        output imem_read_address,
        output if_valid,
        output if_pc,
        output if_instruction,
        output misaligned_error
    );

    // Pipeline / memory environment side
    modport slave (
        output stall_in,
        output redirect_valid,
        output redirect_pc,
        output imem_instruction,
        input  imem_read_address,
        input  if_valid,
        input  if_pc,
        input  if_instruction,
        input  misaligned_error
    );
endinterface

// File: rtl/fetch_controller.sv
// Fetch controller: owns the PC, issues one synchronous-read word request
// per cycle, buffers returning words in a 2-entry fifo and drives the
// registered IF/ID outputs. Stalls hold the outputs without losing words;
// redirects squash every in-flight and buffered word.
module fetch_controller #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic           clk,
    input logic           reset,
    fetch_controller_if.master bus
);

    // Request tracking
    logic [31:0] req_pc_r;
    logic        inflight_r;
    logic [31:0] inflight_pc_r;

    // Fetch buffer: circular, head index plus occupancy 0..2
    logic [31:0] fifo_pc_r    [2];
    logic [31:0] fifo_instr_r [2];
    logic        head_r;
    logic [1:0]  count_r;

    // IF/ID registers
    logic        if_valid_r;
    logic [31:0] if_pc_r;
    logic [31:0] if_instr_r;
    logic        misaligned_r;

    // Per-edge decisions
    logic        push_s;
    logic        pop_s;
    logic [2:0]  occ_s;
    logic        issue_s;
    logic        wr_idx_s;

    // Decide push/pop/issue for the coming edge. Issue only when the word
    // it will return next cycle is guaranteed a free fifo slot.
    always_comb begin
        push_s   = 1'b0;
        pop_s    = 1'b0;
        occ_s    = 3'd0;
        issue_s  = 1'b0;
        wr_idx_s = 1'b0;
        push_s   = inflight_r;
        if (!bus.stall_in && (count_r != 2'd0)) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
        occ_s    = {1'b0, count_r} + {2'b00, push_s} - {2'b00, pop_s};
        issue_s  = (occ_s <= 3'd1);
        // With count 2 the write slot equals the head being popped this edge
        wr_idx_s = head_r ^ count_r[0];
    end

    // Fifo storage: capture the returning word of a tracked request.
    always_ff @(posedge clk) begin
        if (reset) begin
            fifo_pc_r[0]    <= 32'd0;
            fifo_pc_r[1]    <= 32'd0;
            fifo_instr_r[0] <= 32'd0;
            fifo_instr_r[1] <= 32'd0;
        end else if (!bus.redirect_valid && push_s) begin
            fifo_pc_r[wr_idx_s]    <= inflight_pc_r;
            fifo_instr_r[wr_idx_s] <= bus.imem_instruction;
        end
    end

    // Request sequencing, fifo bookkeeping and IF/ID output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_pc_r      <= RESET_PC;
            inflight_r    <= 1'b0;
            inflight_pc_r <= 32'd0;
            head_r        <= 1'b0;
            count_r       <= 2'd0;
            if_valid_r    <= 1'b0;
            if_pc_r       <= 32'd0;
            if_instr_r    <= 32'd0;
            misaligned_r  <= 1'b0;
        end else if (bus.redirect_valid) begin
            // Squash everything; the low address bits are dropped but flagged
            req_pc_r   <= {bus.redirect_pc[31:2], 2'b00};
            inflight_r <= 1'b0;
            head_r     <= 1'b0;
            count_r    <= 2'd0;
            if_valid_r <= 1'b0;
            if (bus.redirect_pc[1:0] != 2'b00) begin
                misaligned_r <= 1'b1;
            end
        end else begin
            count_r <= occ_s[1:0];
            if (pop_s) begin
                head_r <= ~head_r;
            end
            if (!bus.stall_in) begin
                if_valid_r <= (count_r != 2'd0);
                if (count_r != 2'd0) begin
                    if_pc_r    <= fifo_pc_r[head_r];
                    if_instr_r <= fifo_instr_r[head_r];
                end
            end
            if (issue_s) begin
                inflight_r    <= 1'b1;
                inflight_pc_r <= req_pc_r;
                req_pc_r      <= req_pc_r + 32'd4;
            end else begin
                inflight_r <= 1'b0;
            end
        end
    end

    assign bus.imem_read_address = req_pc_r;
    assign bus.if_valid          = if_valid_r;
    assign bus.if_pc             = if_pc_r;
    assign bus.if_instruction    = if_instr_r;
    assign bus.misaligned_error  = misaligned_r;

endmodule
